// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared constants for the EX-stage multiply/divide unit.
//   MD_* operation codes, FSM state encodings and small op-decode helpers.
package md_unit_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        MD_S_IDLE = 2'd0,
        MD_S_RUN  = 2'd1,
        MD_S_FIX  = 2'd2
    } md_state_t;

    // Operations that go through the iterative core.
    function automatic logic md_is_iter(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_unit_iter_core.sv
// md_iter_core: magnitude datapath for md_unit. One multiply or divide step
// per cycle on unsigned operands.
//   clk, rstn  : clock, async active-low reset
//   load       : capture a (multiplicand/dividend) and b (multiplier/divisor),
//                clear the partial result, arm the iteration counter
//   op_is_div  : selects restoring-divide step instead of shift-add multiply
//   step       : perform one iteration
//   a, b       : operand magnitudes
//   result     : multiply -> 2*WIDTH product; divide -> {remainder, quotient}
//   last       : the current step is the final one
module md_iter_core
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load,
    input  logic               op_is_div,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               last
);

    localparam int CW = $clog2(WIDTH + 1);

    // rem_q: upper product half / partial remainder
    // shf_q: multiplier shifting out / dividend shifting out, quotient shifting in
    // m_q  : multiplicand / divisor
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign sum     = {1'b0, rem_q} + (shf_q[0] ? {1'b0, m_q} : '0);
    assign shifted = {rem_q, shf_q[WIDTH-1]};
    // When the subtraction is taken the true difference is below m_q, so the
    // low WIDTH bits are exact.
    assign diff    = shifted[WIDTH-1:0] - m_q;

    always_comb begin
        rem_d = rem_q;
        shf_d = shf_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        if (load) begin
            rem_d = '0;
            shf_d = op_is_div ? a : b;
            m_d   = op_is_div ? b : a;
            cnt_d = CW'(WIDTH);
        end else if (step) begin
            cnt_d = cnt_q - CW'(1);
            if (op_is_div) begin
                if (shifted >= {1'b0, m_q}) begin
                    rem_d = diff;
                    shf_d = {shf_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    shf_d = {shf_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                rem_d = sum[WIDTH:1];
                shf_d = {sum[0], shf_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q <= '0;
            shf_q <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            shf_q <= shf_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    assign result = {rem_q, shf_q};
    assign last   = (cnt_q == CW'(1));

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit owning the HI/LO registers.
//   clk, rstn : clock, async active-low reset
//   flush     : abort in-flight operation (only when MD_FLUSH_EN is defined)
//   md_op     : MD_* operation code
//   start     : issue strobe, accepted when busy=0
//   A, B      : rs / rt operands
//   busy      : operation in flight
//   done      : one-cycle pulse, HI/LO written this cycle
//   hi, lo    : architectural HI/LO
// Optional feature macro: MD_FLUSH_EN adds the flush port.
//
// state      | meaning
// MD_S_IDLE  | accepts start; MTHI/MTLO write directly
// MD_S_RUN   | one core iteration per cycle, WIDTH cycles
// MD_S_FIX   | sign fixup, write HI/LO, pulse done
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
`ifdef MD_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [2:0]       md_op,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             is_div_q;
    logic             neg_res_q;   // product / quotient must be negated
    logic             neg_rem_q;   // remainder takes the negative dividend sign
    logic             bzero_q;     // divide by zero

    logic             kill;
`ifdef MD_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             core_load, core_step, core_div, core_last;
    logic [2*WIDTH-1:0] core_res;

    assign op_signed = md_is_signed(md_op);
    assign a_neg     = op_signed & A[WIDTH-1];
    assign b_neg     = op_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    assign core_load = (state_q == MD_S_IDLE) && start && !kill && md_is_iter(md_op);
    assign core_step = (state_q == MD_S_RUN) && !kill;
    assign core_div  = (state_q == MD_S_IDLE) ? md_is_div(md_op) : is_div_q;

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rstn      (rstn),
        .load      (core_load),
        .op_is_div (core_div),
        .step      (core_step),
        .a         (a_mag),
        .b         (b_mag),
        .result    (core_res),
        .last      (core_last)
    );

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

    assign quo      = core_res[WIDTH-1:0];
    assign rem      = core_res[2*WIDTH-1:WIDTH];
    assign prod_fix = neg_res_q ? -core_res : core_res;
    // Divide by zero: all-ones quotient; the remainder path already yields A.
    assign quo_fix  = bzero_q ? '1 : (neg_res_q ? -quo : quo);
    assign rem_fix  = neg_rem_q ? -rem : rem;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= MD_S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (kill) begin
                // Abort wins over any same-cycle start; HI/LO untouched.
                state_q <= MD_S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    MD_S_IDLE: begin
                        if (start) begin
                            if (md_is_iter(md_op)) begin
                                state_q   <= MD_S_RUN;
                                busy_q    <= 1'b1;
                                is_div_q  <= md_is_div(md_op);
                                neg_res_q <= a_neg ^ b_neg;
                                neg_rem_q <= md_is_div(md_op) & a_neg;
                                bzero_q   <= md_is_div(md_op) & (B == '0);
                            end else if (md_op == MD_MTHI) begin
                                hi_q <= A;
                            end else if (md_op == MD_MTLO) begin
                                lo_q <= A;
                            end
                        end
                    end
                    MD_S_RUN: begin
                        if (core_last) state_q <= MD_S_FIX;
                    end
                    MD_S_FIX: begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MD_S_IDLE;
                    end
                    default: begin
                        state_q <= MD_S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   md_op = MD_NOP;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MD_FLUSH_EN
    logic         flush = 1'b0;
`endif

    md_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rstn  (rstn),
`ifdef MD_FLUSH_EN
        .flush (flush),
`endif
        .md_op (md_op),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           acc;
        int           tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                $display("op %0d: hi=%h lo=%h", e.tag, hi, lo);
                chk($sformatf("hi_op%0d", e.tag), hi, e.hi);
                chk($sformatf("lo_op%0d", e.tag), lo, e.lo);
                chk($sformatf("latency_op%0d", e.tag), W'(cyc - e.acc), W'(W + 1));
                chk($sformatf("busy_at_done_op%0d", e.tag), W'(busy), W'(0));
            end
        end
    end

    // Caller is at a negedge; start is presented for exactly one edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input int tag);
        exp_t e;
        md_op = op;
        A     = a;
        B     = b;
        start = 1'b1;
        if (md_is_iter(op)) begin
            e.hi  = eh;
            e.lo  = el;
            e.acc = cyc + 1;
            e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NOP;
        A     = $urandom;
        B     = $urandom;
        if (md_is_iter(op)) chk($sformatf("busy_after_issue_op%0d", tag), W'(busy), W'(1));
    endtask

    task automatic wait_drain(input int tag);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL timeout_op%0d actual=pending expected=done", tag);
            sb.delete();
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[2] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[5] = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7] = '{MD_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[8] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        // Reset state
        #12;
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // MULT -3 * 7 with a second start raised mid-operation
        issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 100);
        repeat (5) @(negedge clk);
        md_op = MD_MULTU; A = 32'd1; B = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(100);
        repeat (40) @(negedge clk);

        // Directed vector table
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, i);
            wait_drain(i);
            @(negedge clk);
        end

        // Back-to-back: next start presented while done=1
        issue(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 200);
        begin
            int n = 0;
            while (!done && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        issue(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 201);
        wait_drain(201);
        @(negedge clk);

        // MTHI then MTLO in consecutive cycles
        issue(MD_MTHI, 32'hDEADBEEF, '0, '0, '0, 300);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_busy", W'(busy), W'(0));
        issue(MD_MTLO, 32'h0BADF00D, '0, '0, '0, 301);
        chk("mtlo_lo", lo, 32'h0BADF00D);
        chk("mtlo_hi_hold", hi, 32'hDEADBEEF);
        chk("mtlo_busy", W'(busy), W'(0));
        chk("mtlo_done", W'(done), W'(0));

        // NOP and reserved code 7 are ignored
        issue(MD_NOP, 32'h1111, 32'h2222, '0, '0, 302);
        issue(3'd7, 32'h3333, 32'h4444, '0, '0, 303);
        chk("nop_hi", hi, 32'hDEADBEEF);
        chk("nop_lo", lo, 32'h0BADF00D);
        chk("nop_busy", W'(busy), W'(0));

        // MTHI while busy is ignored
        issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 400);
        repeat (3) @(negedge clk);
        md_op = MD_MTHI; A = 32'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_busy_ignored", hi, 32'hDEADBEEF);
        wait_drain(400);
        @(negedge clk);

        // Reset mid DIVU
        issue(MD_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 500);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_hi", hi, '0);
        chk("rst_mid_lo", lo, '0);
        chk("rst_mid_busy", W'(busy), W'(0));
        chk("rst_mid_done", W'(done), W'(0));
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_after_busy", W'(busy), W'(0));
        chk("rst_after_lo", lo, '0);

`ifdef MD_FLUSH_EN
        issue(MD_MTHI, 32'h11, '0, '0, '0, 600);
        issue(MD_MTLO, 32'h22, '0, '0, '0, 601);
        issue(MD_MULTU, 32'd5, 32'd5, 32'd0, 32'd25, 602);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", W'(busy), W'(0));
        sb.delete();
        repeat (40) @(negedge clk);
        chk("flush_hi_hold", hi, 32'h11);
        chk("flush_lo_hold", lo, 32'h22);
        md_op = MD_MTHI; A = 32'h99; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_drops_start", hi, 32'h11);
        issue(MD_MULTU, 32'd5, 32'd5, 32'd0, 32'd25, 603);
        wait_drain(603);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit for the EX stage, alongside the ALU; takes the same A/B operands the ALU receives from the register file.
- Owns the architectural HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Multi-cycle; exposes busy so control can stall MFHI/MFLO and further md ops until the result is written.

Parameters:
- WIDTH, 32, operand width; operation latency is WIDTH+1 cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- md_op  in  3  operation code (MD_* constants).
- start  in  1  issue strobe; accepted when start=1 and busy=0.
- A  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- B  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO updated this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- flush  in  1  abort in-flight operation (MD_FLUSH_EN only).

Behaviour:
- Reset, asynchronous on rstn=0: hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0. Reset mid-operation discards the operation.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN: start & MULT/MULTU/DIV/DIVU.
  - RUN: counts WIDTH iterations, one per cycle, then goes to FIX.
  - FIX -> IDLE: HI/LO written, done=1 for that cycle.
- Timing: start accepted at edge N. busy=1 after edges N+1 .. N+WIDTH. hi/lo valid and done=1 after edge N+WIDTH+1, when busy returns to 0.
- MTHI/MTLO: with start in IDLE, hi (or lo) <= A at the next edge. No busy, no done.
- MD_NOP, or codes 7+: ignored.
- start while busy=1: ignored; no queuing. A/B are captured at acceptance, so later A/B changes have no effect.
- Back-to-back: a new start is accepted in the cycle done=1.
- Operand capture at start:
  - Signed ops: capture magnitudes |A|, |B| plus the two sign bits.
  - Unsigned ops: operands are used raw.
- Multiply: radix-2 shift-add on magnitudes into a 2*WIDTH accumulator. In FIX, negate the 2*WIDTH product if the signs differ (MULT only). Then {hi,lo} <= product.
- Divide: restoring, one quotient bit per cycle.
  - FIX, DIV only: quotient is negated if signs differ; remainder takes the dividend's sign.
  - Result: lo <= quotient, hi <= remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0 (wrap, no trap).
- Divide by zero: full latency still applies. Result is lo=0xFFFFFFFF, hi=A, for both DIV and DIVU.
- HI/LO are written only in FIX or by MTHI/MTLO; otherwise they hold.

Optional Feature:
- Macro: MD_FLUSH_EN.
- Defined:
  - flush port exists.
  - flush=1 at any edge forces FSM to IDLE and busy=0, with no done and hi/lo unchanged.
  - flush has priority over a same-cycle start; that start is dropped.
  - flush in IDLE has no effect.
- Undefined: port absent; operations always complete.

Decomposition:
- Shared define header, alongside the ALU op codes:
  - MD_NOP=3'd0, MD_MULT=3'd1, MD_MULTU=3'd2, MD_DIV=3'd3, MD_DIVU=3'd4, MD_MTHI=3'd5, MD_MTLO=3'd6.
  - FSM state encodings MD_S_IDLE/RUN/FIX.
- Sub-module md_iter_core:
  - Holds the magnitude accumulator/remainder, the quotient/multiplier shift register and the iteration counter.
  - Inputs: load, op_is_div, step. Outputs: result and last flag.
- Sign fixup and HI/LO registers stay in md_unit.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy for 32 cycles, done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT A=-3 (0xFFFFFFFD), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Second start raised mid-operation is ignored and the result is unchanged.
- DIV A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU A=100, B=7 -> lo=14, hi=2.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 cycles.
- MTHI A=0xDEADBEEF, then MTLO A=0x0BADF00D in consecutive cycles -> hi/lo updated next edge, busy never set. MTHI issued while busy -> ignored.
- rstn low at iteration 10 of DIVU -> hi=lo=0, busy=0 immediately, no done. With MD_FLUSH_EN: flush at iteration 5 -> busy=0 next edge, hi/lo hold their prior values.
